// File: rtl/biriscv_div_arbiter.sv
// Shares the single iterative divider between the two issue pipes: round-robin
// grant, one-cycle start pulse, result routing, flush draining and a watchdog.
module biriscv_div_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [31:0] req0_ra_operand_i,
  input  logic [31:0] req0_rb_operand_i,
  input  logic [4:0]  req0_rd_idx_i,
  output logic        req0_accept_o,

  input  logic        req1_valid_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [31:0] req1_ra_operand_i,
  input  logic [31:0] req1_rb_operand_i,
  input  logic [4:0]  req1_rd_idx_i,
  output logic        req1_accept_o,

  input  logic        flush_i,

  output logic        div_opcode_valid_o,
  output logic [31:0] div_opcode_opcode_o,
  output logic [31:0] div_ra_operand_o,
  output logic [31:0] div_rb_operand_o,

  input  logic        div_writeback_valid_i,
  input  logic [31:0] div_writeback_value_i,

  output logic        wb_valid_o,
  output logic        wb_port_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,

  output logic        busy_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic [7:0]  wdog_q;
  logic        error_q;

  logic [31:0] opcode_q, ra_q, rb_q;
  logic [4:0]  rd_q;
  logic        port_q;

  logic        wb_valid_q, wb_port_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_value_q;

  logic        grant0, grant1;
  logic        accept0, accept1;
  logic        in_flight;
  logic        timeout_hit;
  logic        wb_take;

  // Handshake: a request transfers in the cycle reqN_valid_i and reqN_accept_o
  // are both high; accept never depends on anything but IDLE, flush and grant.
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
  end

  assign accept0 = (state_q == ST_IDLE) & ~flush_i & grant0;
  assign accept1 = (state_q == ST_IDLE) & ~flush_i & grant1;

  assign in_flight   = (state_q == ST_WAIT) | (state_q == ST_DRAIN);
  assign timeout_hit = in_flight & (wdog_q == WDOG_LAST) & ~div_writeback_valid_i;
  assign wb_take     = (state_q == ST_WAIT) & div_writeback_valid_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept0 | accept1) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = flush_i ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // A flush cannot stop the divider, so wait out its result in DRAIN.
        if (div_writeback_valid_i)  state_d = ST_IDLE;
        else if (timeout_hit)       state_d = ST_IDLE;
        else if (flush_i)           state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (div_writeback_valid_i | timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wdog_q       <= 8'd0;
      error_q      <= 1'b0;
      opcode_q     <= 32'd0;
      ra_q         <= 32'd0;
      rb_q         <= 32'd0;
      rd_q         <= 5'd0;
      port_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_port_q    <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_value_q   <= 32'd0;
    end else begin
      state_q <= state_d;

      if (accept0 | accept1) begin
        opcode_q     <= accept1 ? req1_opcode_i     : req0_opcode_i;
        ra_q         <= accept1 ? req1_ra_operand_i : req0_ra_operand_i;
        rb_q         <= accept1 ? req1_rb_operand_i : req0_rb_operand_i;
        rd_q         <= accept1 ? req1_rd_idx_i     : req0_rd_idx_i;
        port_q       <= accept1;
        last_grant_q <= accept1;
      end

      // Clearing in ISSUE means the count starts at zero on the first WAIT cycle.
      if (state_q == ST_ISSUE) wdog_q <= 8'd0;
      else if (in_flight)      wdog_q <= wdog_q + 8'd1;

      if (timeout_hit) error_q <= 1'b1;

      wb_valid_q <= wb_take;
      if (wb_take) begin
        wb_port_q  <= port_q;
        wb_rd_q    <= rd_q;
        wb_value_q <= div_writeback_value_i;
      end
    end
  end

  assign req0_accept_o       = accept0;
  assign req1_accept_o       = accept1;
  assign div_opcode_valid_o  = (state_q == ST_ISSUE) & ~flush_i;
  assign div_opcode_opcode_o = opcode_q;
  assign div_ra_operand_o    = ra_q;
  assign div_rb_operand_o    = rb_q;
  assign wb_valid_o          = wb_valid_q;
  assign wb_port_o           = wb_port_q;
  assign wb_rd_idx_o         = wb_rd_q;
  assign wb_value_o          = wb_value_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign error_o             = error_q;

endmodule

// File: tb/tb_biriscv_div_arbiter.sv
// Directed bench for biriscv_div_arbiter: the divider is played by the bench,
// which pulses div_writeback_valid_i at hand-chosen cycles.
module tb_biriscv_div_arbiter;

  localparam logic [31:0] OP_DIV  = 32'h02c5_c533;
  localparam logic [31:0] OP_DIVU = 32'h02c5_d533;
  localparam logic [31:0] OP_REM  = 32'h02c5_e533;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [31:0] req0_opcode_i, req0_ra_operand_i, req0_rb_operand_i;
  logic [31:0] req1_opcode_i, req1_ra_operand_i, req1_rb_operand_i;
  logic [4:0]  req0_rd_idx_i, req1_rd_idx_i;
  logic        req0_accept_o, req1_accept_o;
  logic        flush_i;
  logic        div_opcode_valid_o;
  logic [31:0] div_opcode_opcode_o, div_ra_operand_o, div_rb_operand_o;
  logic        div_writeback_valid_i;
  logic [31:0] div_writeback_value_i;
  logic        wb_valid_o, wb_port_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_value_o;
  logic        busy_o, error_o;

  int n_checks = 0;
  int n_errors = 0;

  biriscv_div_arbiter #(.TIMEOUT(40)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .req0_valid_i          (req0_valid_i),
    .req0_opcode_i         (req0_opcode_i),
    .req0_ra_operand_i     (req0_ra_operand_i),
    .req0_rb_operand_i     (req0_rb_operand_i),
    .req0_rd_idx_i         (req0_rd_idx_i),
    .req0_accept_o         (req0_accept_o),
    .req1_valid_i          (req1_valid_i),
    .req1_opcode_i         (req1_opcode_i),
    .req1_ra_operand_i     (req1_ra_operand_i),
    .req1_rb_operand_i     (req1_rb_operand_i),
    .req1_rd_idx_i         (req1_rd_idx_i),
    .req1_accept_o         (req1_accept_o),
    .flush_i               (flush_i),
    .div_opcode_valid_o    (div_opcode_valid_o),
    .div_opcode_opcode_o   (div_opcode_opcode_o),
    .div_ra_operand_o      (div_ra_operand_o),
    .div_rb_operand_o      (div_rb_operand_o),
    .div_writeback_valid_i (div_writeback_valid_i),
    .div_writeback_value_i (div_writeback_value_i),
    .wb_valid_o            (wb_valid_o),
    .wb_port_o             (wb_port_o),
    .wb_rd_idx_o           (wb_rd_idx_o),
    .wb_value_o            (wb_value_o),
    .busy_o                (busy_o),
    .error_o               (error_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    req0_valid_i = 1'b0; req0_opcode_i = '0; req0_ra_operand_i = '0;
    req0_rb_operand_i = '0; req0_rd_idx_i = '0;
    req1_valid_i = 1'b0; req1_opcode_i = '0; req1_ra_operand_i = '0;
    req1_rb_operand_i = '0; req1_rd_idx_i = '0;
    flush_i = 1'b0;
    div_writeback_valid_i = 1'b0; div_writeback_value_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic drive_req0(input logic [31:0] op, input logic [31:0] ra,
                            input logic [31:0] rb, input logic [4:0] rd);
    req0_valid_i = 1'b1; req0_opcode_i = op;
    req0_ra_operand_i = ra; req0_rb_operand_i = rb; req0_rd_idx_i = rd;
  endtask

  task automatic drive_req1(input logic [31:0] op, input logic [31:0] ra,
                            input logic [31:0] rb, input logic [4:0] rd);
    req1_valid_i = 1'b1; req1_opcode_i = op;
    req1_ra_operand_i = ra; req1_rb_operand_i = rb; req1_rd_idx_i = rd;
  endtask

  initial begin
    int g;

    // Reset state
    rst_i = 1'b1;
    clear_inputs();
    step();
    step();
    check("rst_busy", busy_o, 0);
    check("rst_error", error_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_div_valid", div_opcode_valid_o, 0);
    check("rst_div_ra", div_ra_operand_o, 0);
    check("rst_wb_value", wb_value_o, 0);
    check("rst_wb_rd", wb_rd_idx_o, 0);
    check("rst_wb_port", wb_port_o, 0);
    rst_i = 1'b0;

    // Single request: DIVU 100/7 -> 14 on rd 5
    drive_req0(OP_DIVU, 32'd100, 32'd7, 5'd5);
    #1;
    check("t1_acc0", req0_accept_o, 1);
    check("t1_acc1", req1_accept_o, 0);
    step();
    req0_valid_i = 1'b0;
    #1;
    check("t1_start", div_opcode_valid_o, 1);
    check("t1_opcode", div_opcode_opcode_o, OP_DIVU);
    check("t1_ra", div_ra_operand_o, 32'd100);
    check("t1_rb", div_rb_operand_o, 32'd7);
    check("t1_busy_issue", busy_o, 1);
    step();
    #1;
    check("t1_start_low", div_opcode_valid_o, 0);
    check("t1_ra_hold", div_ra_operand_o, 32'd100);
    check("t1_busy_wait", busy_o, 1);
    repeat (3) begin
      step();
      #1;
      check("t1_no_wb", wb_valid_o, 0);
    end
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd14;
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t1_wb_valid", wb_valid_o, 1);
    check("t1_wb_port", wb_port_o, 0);
    check("t1_wb_rd", wb_rd_idx_o, 5);
    check("t1_wb_value", wb_value_o, 32'd14);
    check("t1_idle", busy_o, 0);
    step();
    #1;
    check("t1_wb_pulse", wb_valid_o, 0);
    check("t1_wb_hold", wb_value_o, 32'd14);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    drive_req0(OP_DIV, 32'd200, 32'd3, 5'd10);
    drive_req1(OP_REM, 32'd300, 32'd4, 5'd11);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      check("t2_acc0", req0_accept_o, (g == 0) ? 1 : 0);
      check("t2_acc1", req1_accept_o, (g == 1) ? 1 : 0);
      step();
      #1;
      check("t2_start", div_opcode_valid_o, 1);
      check("t2_ra", div_ra_operand_o, (g == 1) ? 32'd300 : 32'd200);
      check("t2_acc_issue", {req1_accept_o, req0_accept_o}, 0);
      step();
      #1;
      check("t2_acc_wait", {req1_accept_o, req0_accept_o}, 0);
      div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd1000 + 32'(k);
      step();
      div_writeback_valid_i = 1'b0;
      if (k == 3) begin
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
      end
      #1;
      check("t2_wb_valid", wb_valid_o, 1);
      check("t2_wb_port", wb_port_o, 32'(g));
      check("t2_wb_rd", wb_rd_idx_o, (g == 1) ? 32'd11 : 32'd10);
      check("t2_wb_value", wb_value_o, 32'd1000 + 32'(k));
    end
    step();
    #1;
    check("t2_idle", busy_o, 0);

    // Flush in ISSUE: divider never started, stray return ignored
    req1_valid_i = 1'b1;
    #1;
    check("t3_acc1", req1_accept_o, 1);
    step();
    req1_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    check("t3_no_start", div_opcode_valid_o, 0);
    check("t3_busy", busy_o, 1);
    step();
    flush_i = 1'b0;
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd55;
    #1;
    check("t3_idle", busy_o, 0);
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t3_no_wb", wb_valid_o, 0);
    check("t3_wb_value_hold", wb_value_o, 32'd1003);

    // Flush in WAIT: REM -7/2, result -1 discarded in DRAIN
    drive_req0(OP_REM, 32'hffff_fff9, 32'd2, 5'd7);
    #1;
    check("t4_acc0", req0_accept_o, 1);
    step();
    req0_valid_i = 1'b0;
    #1;
    check("t4_start", div_opcode_valid_o, 1);
    check("t4_ra", div_ra_operand_o, 32'hffff_fff9);
    repeat (4) step();
    flush_i = 1'b1;
    #1;
    check("t4_busy_flush", busy_o, 1);
    step();
    flush_i = 1'b0;
    req0_valid_i = 1'b1;
    #1;
    check("t4_drain_no_acc", req0_accept_o, 0);
    check("t4_busy_drain", busy_o, 1);
    req0_valid_i = 1'b0;
    step();
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'hffff_ffff;
    #1;
    check("t4_busy_ret", busy_o, 1);
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t4_no_wb", wb_valid_o, 0);
    check("t4_idle", busy_o, 0);
    check("t4_wb_value_hold", wb_value_o, 32'd1003);

    // Back-to-back: pipe 1 accepted in the wb_valid cycle
    drive_req0(OP_DIVU, 32'd81, 32'd9, 5'd3);
    #1;
    check("t5_acc0", req0_accept_o, 1);
    step();
    req0_valid_i = 1'b0;
    step();
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd9;
    step();
    div_writeback_valid_i = 1'b0;
    drive_req1(OP_DIVU, 32'd77, 32'd7, 5'd12);
    #1;
    check("t5_wb_valid", wb_valid_o, 1);
    check("t5_wb_rd", wb_rd_idx_o, 5'd3);
    check("t5_wb_value", wb_value_o, 32'd9);
    check("t5_acc1", req1_accept_o, 1);
    step();
    req1_valid_i = 1'b0;
    #1;
    check("t5_start", div_opcode_valid_o, 1);
    check("t5_ra", div_ra_operand_o, 32'd77);
    check("t5_wb_pulse", wb_valid_o, 0);
    step();
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd11;
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t5_wb2_port", wb_port_o, 1);
    check("t5_wb2_rd", wb_rd_idx_o, 5'd12);
    check("t5_wb2_value", wb_value_o, 32'd11);

    // Watchdog: no return for 40 WAIT cycles
    drive_req0(OP_DIVU, 32'd5, 32'd0, 5'd1);
    #1;
    check("t6_acc0", req0_accept_o, 1);
    step();
    req0_valid_i = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      check("t6_no_error", error_o, 0);
      check("t6_busy", busy_o, 1);
      step();
    end
    check("t6_error", error_o, 1);
    check("t6_idle", busy_o, 0);
    check("t6_no_wb", wb_valid_o, 0);
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd77;
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t6_late_no_wb", wb_valid_o, 0);
    check("t6_error_sticky", error_o, 1);

    // Reset mid-operation; a later return produces nothing
    drive_req1(OP_DIV, 32'd9, 32'd3, 5'd2);
    #1;
    check("t7_acc1", req1_accept_o, 1);
    step();
    req1_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("t7_idle", busy_o, 0);
    check("t7_error_clr", error_o, 0);
    div_writeback_valid_i = 1'b1; div_writeback_value_i = 32'd123;
    step();
    div_writeback_valid_i = 1'b0;
    #1;
    check("t7_no_wb", wb_valid_o, 0);
    check("t7_wb_value", wb_value_o, 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/biriscv_div_arbiter.md
# biriscv_div_arbiter

Sequencing controller that shares the single iterative divide/remainder unit between the two issue pipes of the dual-issue core. Grants one DIV/DIVU/REM/REMU request at a time with round-robin priority, and issues the request to the divider as a one-cycle start pulse. Tracks the operation until the divider returns its result, then routes the result to the owning pipe with its destination register. Also handles pipeline flushes, because an operation already started in the divider cannot be aborted.

## Interface
- TIMEOUT, default 40: watchdog limit, in cycles spent in WAIT or DRAIN; legal range 36..255.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req0_valid_i  in  1  pipe 0 has a divide-class instruction.
- req0_opcode_i  in  32  instruction word.
- req0_ra_operand_i, req0_rb_operand_i  in  32 each  source operands.
- req0_rd_idx_i  in  5  destination register.
- req0_accept_o  out  1  combinational; the request is taken this cycle.
- req1_* ports, same as req0_*, for pipe 1.
- flush_i  in  1  kills any in-flight or presented operation.
- div_opcode_valid_o  out  1  start pulse to the divider.
- div_opcode_opcode_o, div_ra_operand_o, div_rb_operand_o  out  32 each  captured request fields.
- div_writeback_valid_i  in  1  divider result valid, one-cycle pulse.
- div_writeback_value_i  in  32  divider result.
- wb_valid_o  out  1  result valid to the pipes, one-cycle pulse.
- wb_port_o  out  1  owning pipe (0 or 1).
- wb_rd_idx_o  out  5  owning destination register.
- wb_value_o  out  32  result.
- busy_o  out  1  high whenever state is not IDLE.
- error_o  out  1  sticky watchdog error flag.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - Grant is decided by round-robin. If both pipes request, the pipe other than last_grant wins. If only one requests, it wins.
  - reqN_accept_o = IDLE & !flush_i & reqN_valid_i & granted(N).
  - On accept: capture opcode, operands, rd_idx and port; update last_grant; go to ISSUE.
- ISSUE:
  - div_opcode_valid_o = !flush_i.
  - If flush_i: go to IDLE; the divider is never started.
  - Otherwise: go to WAIT.
- WAIT:
  - On div_writeback_valid_i, register value, port and rd_idx into wb_*; set wb_valid_o next cycle; go to IDLE.
  - If flush_i (including the same cycle as div_writeback_valid_i): the result is discarded. With a same-cycle return go to IDLE, otherwise go to DRAIN.
- DRAIN:
  - Accepts nothing.
  - On div_writeback_valid_i: discard the result and go to IDLE.
  - A flush_i in DRAIN has no further effect.
- Watchdog:
  - The counter clears on entry to WAIT and increments each cycle in WAIT or DRAIN.
  - At count == TIMEOUT-1 with no return: set error_o (held until rst_i), abandon the operation and go to IDLE. No writeback is produced.
- div_writeback_valid_i seen in IDLE or ISSUE is ignored and produces no wb_valid_o.
- Operand fields are passed unmodified; sign handling belongs to the divider.
- div_* data outputs hold the captured values outside the start pulse.

## Timing
- Reset values:
  - state IDLE; last_grant = 1, so pipe 0 wins first contention.
  - All *_accept_o, div_opcode_valid_o, wb_valid_o, busy_o and error_o are 0.
  - div_* data outputs, wb_port_o, wb_rd_idx_o and wb_value_o are 0; the watchdog counter is 0.
- Reset asserted mid-operation returns the block to IDLE next edge. A divider return after that reset produces nothing.
- Accept in cycle T → div_opcode_valid_o in T+1 → WAIT from T+2.
- div_writeback_valid_i in cycle R → wb_valid_o in R+1. The block is in IDLE in R+1 and may accept a new request in that same cycle.
- Divider return latency ranges from 2 cycles (repeat operands) to 34 cycles. Accept-to-wb_valid_o is therefore 4..36 cycles.
- At most one operation is outstanding; the throughput bound is one per (latency+2) cycles.
- busy_o is high from T+1 until the cycle state re-enters IDLE.

## Test plan
- Single request: pipe 0 sends DIVU 100/7 with rd=5 → accept in T, start pulse in T+1; divider returns 14 → wb_valid_o=1, wb_port_o=0, wb_rd_idx_o=5, wb_value_o=14 one cycle after the return.
- Contention: both pipes request every cycle after reset → grant order 0, 1, 0, 1. The losing pipe's accept stays 0 until IDLE.
- Flush in ISSUE: flush_i asserted at T+1 → div_opcode_valid_o=0; IDLE at T+2; no wb_valid_o.
- Flush in WAIT: REM -7/2 started, flush 5 cycles later → DRAIN. The divider return of -1 is discarded; wb_valid_o stays 0 and busy_o drops after the return.
- Back-to-back: a return at R with a new pipe 1 request at R+1 → accept at R+1, wb_valid_o at R+1, next start pulse at R+2.
- Watchdog: with TIMEOUT=40, the divider never returns → error_o rises after 40 WAIT cycles, state returns to IDLE, error_o stays high until rst_i.
